// File: rtl/pong_pkg.sv
// Shared pong game-flow types: FSM states, phase codes and side constants.
// The drawer imports this package to decode PHASE.
package pong_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_RALLY = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_SERVE = 3'd1;
  localparam logic [2:0] PH_RALLY = 3'd2;
  localparam logic [2:0] PH_POINT = 3'd3;
  localparam logic [2:0] PH_OVER  = 3'd4;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  function automatic logic [2:0] phase_of(input state_e s);
    return 3'(s);
  endfunction

endpackage

// File: rtl/pong_btn_sync.sv
// Asynchronous button synchronizer with rising-edge detect.
// press_o is a single-cycle pulse per button press.
module pong_btn_sync (
  input  logic CLK,
  input  logic RST,
  input  logic btn_i,
  output logic press_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign press_o = s2_q & ~s3_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: frame step enables, serve/rally/point/over
// sequencing and score ownership.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCR_W      = 30,
  parameter int SCR_H      = 20,
  parameter int MAX_SCORE  = 10,
  parameter int SCORE_W    = 4,
  parameter int BALL_DIV   = 4,
  parameter int PADDLE_DIV = 2,
  parameter int SERVE_FR   = 60
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [10:0]        H_CNT,
  input  logic [10:0]        V_CNT,
  input  logic               Button_A,
  input  logic               Button_B,
  input  logic               L_MISS,
  input  logic               R_MISS,
  output logic               BALL_STEP,
  output logic               PADDLE_STEP,
  output logic               BALL_RESET,
  output logic               SERVE_DIR,
  output logic [SCORE_W-1:0] L_SCORE,
  output logic [SCORE_W-1:0] R_SCORE,
  output logic               GAME_OVER,
  output logic               WINNER,
  output logic [2:0]         PHASE
);

  localparam int BW = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;
  localparam int PW = (PADDLE_DIV > 1) ? $clog2(PADDLE_DIV) : 1;
  localparam int SW = (SERVE_FR > 1) ? $clog2(SERVE_FR) : 1;

  localparam logic [BW-1:0] B_LAST = BW'(BALL_DIV - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PADDLE_DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SERVE_FR - 1);
  localparam logic [SCORE_W-1:0] S_MAX = SCORE_W'(MAX_SCORE);

  if (SCR_W < 1 || SCR_H < 1) begin : g_bad_scr
    $error("pong_game_ctrl: empty playfield");
  end
  if ((2 ** SCORE_W) <= MAX_SCORE) begin : g_bad_score
    $error("pong_game_ctrl: SCORE_W too narrow");
  end

  state_e             state_q;
  logic               hit_d;
  logic               hit_q;
  logic               tick_q;
  logic [BW-1:0]      bdiv_q;
  logic [PW-1:0]      pdiv_q;
  logic [SW-1:0]      serve_cnt_q;
  logic               ball_step_q;
  logic               paddle_step_q;
  logic               ball_reset_q;
  logic               serve_dir_q;
  logic               scorer_q;
  logic               winner_q;
  logic [SCORE_W-1:0] l_score_q;
  logic [SCORE_W-1:0] r_score_q;
  logic [SCORE_W-1:0] l_inc_d;
  logic [SCORE_W-1:0] r_inc_d;
  logic               press_a;
  logic               press_b;

  pong_btn_sync u_btn_a (
    .CLK     (CLK),
    .RST     (RST),
    .btn_i   (Button_A),
    .press_o (press_a)
  );

  pong_btn_sync u_btn_b (
    .CLK     (CLK),
    .RST     (RST),
    .btn_i   (Button_B),
    .press_o (press_b)
  );

  assign hit_d = (H_CNT == '0) && (V_CNT == '0);

  always_comb begin
    l_inc_d = l_score_q;
    r_inc_d = r_score_q;
    if (l_score_q < S_MAX) l_inc_d = l_score_q + 1'b1;
    if (r_score_q < S_MAX) r_inc_d = r_score_q + 1'b1;
  end

  // Later non-blocking writes (serve entry) override the divider updates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      hit_q         <= 1'b0;
      tick_q        <= 1'b0;
      bdiv_q        <= '0;
      pdiv_q        <= '0;
      serve_cnt_q   <= '0;
      ball_step_q   <= 1'b0;
      paddle_step_q <= 1'b0;
      ball_reset_q  <= 1'b0;
      serve_dir_q   <= 1'b0;
      scorer_q      <= 1'b0;
      winner_q      <= 1'b0;
      l_score_q     <= '0;
      r_score_q     <= '0;
    end else begin
      hit_q         <= hit_d;
      tick_q        <= hit_d & ~hit_q;
      ball_step_q   <= 1'b0;
      paddle_step_q <= 1'b0;
      ball_reset_q  <= 1'b0;

      if (tick_q && (state_q == S_SERVE || state_q == S_RALLY)) begin
        if (pdiv_q == P_LAST) begin
          pdiv_q        <= '0;
          paddle_step_q <= 1'b1;
        end else begin
          pdiv_q <= pdiv_q + 1'b1;
        end
      end

      if (tick_q && state_q == S_RALLY) begin
        if (bdiv_q == B_LAST) begin
          bdiv_q      <= '0;
          ball_step_q <= 1'b1;
        end else begin
          bdiv_q <= bdiv_q + 1'b1;
        end
      end

      unique case (state_q)
        S_IDLE: begin
          if (press_a | press_b) begin
            serve_dir_q  <= press_b;
            state_q      <= S_SERVE;
            ball_reset_q <= 1'b1;
            pdiv_q       <= '0;
            serve_cnt_q  <= '0;
          end
        end
        S_SERVE: begin
          if (tick_q) begin
            if (serve_cnt_q == S_LAST) begin
              state_q <= S_RALLY;
              bdiv_q  <= '0;
            end else begin
              serve_cnt_q <= serve_cnt_q + 1'b1;
            end
          end
        end
        S_RALLY: begin
          if (L_MISS && !R_MISS) begin
            scorer_q <= SIDE_RIGHT;
            state_q  <= S_POINT;
          end else if (R_MISS && !L_MISS) begin
            scorer_q <= SIDE_LEFT;
            state_q  <= S_POINT;
          end else if (L_MISS && R_MISS) begin
            state_q      <= S_SERVE;
            ball_reset_q <= 1'b1;
            pdiv_q       <= '0;
            serve_cnt_q  <= '0;
          end
        end
        S_POINT: begin
          if (scorer_q == SIDE_LEFT) begin
            l_score_q   <= l_inc_d;
            serve_dir_q <= SIDE_RIGHT;
          end else begin
            r_score_q   <= r_inc_d;
            serve_dir_q <= SIDE_LEFT;
          end
          if ((scorer_q == SIDE_LEFT && l_inc_d == S_MAX) ||
              (scorer_q == SIDE_RIGHT && r_inc_d == S_MAX)) begin
            state_q  <= S_OVER;
            winner_q <= scorer_q;
          end else begin
            state_q      <= S_SERVE;
            ball_reset_q <= 1'b1;
            pdiv_q       <= '0;
            serve_cnt_q  <= '0;
          end
        end
        S_OVER: begin
          if (press_a | press_b) begin
            l_score_q <= '0;
            r_score_q <= '0;
            winner_q  <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BALL_STEP   = ball_step_q;
  assign PADDLE_STEP = paddle_step_q;
  assign BALL_RESET  = ball_reset_q;
  assign SERVE_DIR   = serve_dir_q;
  assign L_SCORE     = l_score_q;
  assign R_SCORE     = r_score_q;
  assign GAME_OVER   = (state_q == S_OVER);
  assign WINNER      = winner_q;
  assign PHASE       = phase_of(state_q);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl on a miniature 40-cycle frame.
// Stimulus queues expected pulses/snapshots; a negedge monitor checks them.
module tb_pong_game_ctrl;

  localparam int FL = 40;

  logic        clk = 1'b0;
  logic        RST;
  logic [10:0] H_CNT;
  logic [10:0] V_CNT;
  logic        Button_A;
  logic        Button_B;
  logic        L_MISS;
  logic        R_MISS;
  logic        BALL_STEP;
  logic        PADDLE_STEP;
  logic        BALL_RESET;
  logic        SERVE_DIR;
  logic [3:0]  L_SCORE;
  logic [3:0]  R_SCORE;
  logic        GAME_OVER;
  logic        WINNER;
  logic [2:0]  PHASE;

  pong_game_ctrl #(
    .SCR_W(30), .SCR_H(20), .MAX_SCORE(3), .SCORE_W(4),
    .BALL_DIV(4), .PADDLE_DIV(2), .SERVE_FR(3)
  ) dut (
    .CLK(clk), .RST(RST), .H_CNT(H_CNT), .V_CNT(V_CNT),
    .Button_A(Button_A), .Button_B(Button_B),
    .L_MISS(L_MISS), .R_MISS(R_MISS),
    .BALL_STEP(BALL_STEP), .PADDLE_STEP(PADDLE_STEP),
    .BALL_RESET(BALL_RESET), .SERVE_DIR(SERVE_DIR),
    .L_SCORE(L_SCORE), .R_SCORE(R_SCORE),
    .GAME_OVER(GAME_OVER), .WINNER(WINNER), .PHASE(PHASE)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [16:0] val;
  } snap_t;

  int    cyc = 0;
  int    pos = 0;
  int    frame = 0;
  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    ball_q[$];
  int    pad_q[$];
  int    rst_q[$];
  snap_t snap_q[$];

  initial begin
    H_CNT = '0;
    V_CNT = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      pos = (pos == FL - 1) ? 0 : pos + 1;
      if (pos == 0) frame++;
      H_CNT = 11'(pos % 10);
      V_CNT = 11'(pos / 10);
    end
  end

  function automatic logic [16:0] mk(input logic [2:0] ph,
                                     input logic [3:0] l,
                                     input logic [3:0] r,
                                     input logic d,
                                     input logic g,
                                     input logic w);
    return {ph, l, r, d, g, w, 3'b000};
  endfunction

  task automatic note(input string nm, input int exp_f, input int act_f);
    total_cnt++;
    if (exp_f == act_f) pass_cnt++;
    else $display("FAIL %s: pulse in frame %0d, required frame %0d (-1 none)",
                  nm, act_f, exp_f);
  endtask

  initial begin : monitor
    logic [16:0] act;
    snap_t       s;
    forever begin
      @(negedge clk);
      if (BALL_STEP === 1'b1)
        note("ball_step", (ball_q.size() != 0) ? ball_q.pop_front() : -1, frame);
      if (PADDLE_STEP === 1'b1)
        note("paddle_step", (pad_q.size() != 0) ? pad_q.pop_front() : -1, frame);
      if (BALL_RESET === 1'b1)
        note("ball_reset", (rst_q.size() != 0) ? rst_q.pop_front() : -1, frame);
      if (snap_q.size() != 0 && snap_q[0].cyc == cyc) begin
        s   = snap_q.pop_front();
        act = {PHASE, L_SCORE, R_SCORE, SERVE_DIR, GAME_OVER, WINNER,
               BALL_STEP, PADDLE_STEP, BALL_RESET};
        total_cnt++;
        if (act === s.val) pass_cnt++;
        else $display("FAIL %s: got %b, required %b", s.name, act, s.val);
      end
    end
  end

  task automatic wait_at(input int f, input int p);
    while ((frame < f) || (frame == f && pos < p)) @(negedge clk);
  endtask

  task automatic snap(input string nm, input logic [16:0] v);
    snap_t s;
    s.cyc  = cyc + 1;
    s.name = nm;
    s.val  = v;
    snap_q.push_back(s);
  endtask

  task automatic expect_round(input int f, input int last);
    rst_q.push_back(f);
    for (int k = f + 2; k <= last; k += 2) pad_q.push_back(k);
    for (int k = f + 7; k <= last; k += 4) ball_q.push_back(k);
  endtask

  task automatic press(input bit b);
    if (b) Button_B = 1'b1;
    else Button_A = 1'b1;
    repeat (5) @(negedge clk);
    Button_A = 1'b0;
    Button_B = 1'b0;
  endtask

  task automatic miss(input bit l, input bit r);
    L_MISS = l;
    R_MISS = r;
    @(negedge clk);
    L_MISS = 1'b0;
    R_MISS = 1'b0;
  endtask

  task automatic queue_empty(input string nm, input int n);
    total_cnt++;
    if (n == 0) pass_cnt++;
    else $display("FAIL %s: %0d expected pulses never seen, required 0", nm, n);
  endtask

  initial begin
    RST = 1'b1;
    Button_A = 1'b0;
    Button_B = 1'b0;
    L_MISS = 1'b0;
    R_MISS = 1'b0;
    repeat (2) @(negedge clk);
    RST = 1'b0;

    wait_at(5, 10);
    snap("idle", mk(3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));

    wait_at(5, 20);
    expect_round(5, 17);
    press(1'b1);
    wait_at(5, 30);
    snap("serve_b", mk(3'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0));

    wait_at(17, 20);
    expect_round(17, 25);
    miss(1'b0, 1'b1);
    wait_at(17, 30);
    snap("left_point", mk(3'd1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0));

    wait_at(25, 20);
    expect_round(25, 29);
    miss(1'b1, 1'b0);
    wait_at(25, 30);
    snap("right_point", mk(3'd1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0));

    wait_at(29, 20);
    expect_round(29, 37);
    miss(1'b1, 1'b1);
    wait_at(29, 30);
    snap("both_miss", mk(3'd1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0));

    wait_at(37, 20);
    expect_round(37, 41);
    miss(1'b1, 1'b0);
    wait_at(37, 30);
    snap("right_2", mk(3'd1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0));

    wait_at(41, 20);
    miss(1'b1, 1'b0);
    wait_at(41, 30);
    snap("game_over", mk(3'd4, 4'd1, 4'd3, 1'b0, 1'b1, 1'b1));
    wait_at(43, 10);
    snap("over_hold", mk(3'd4, 4'd1, 4'd3, 1'b0, 1'b1, 1'b1));

    wait_at(44, 20);
    press(1'b0);
    wait_at(44, 30);
    snap("restart", mk(3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));

    wait_at(46, 20);
    expect_round(46, 54);
    press(1'b1);
    wait_at(46, 30);
    snap("serve_again", mk(3'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0));

    wait_at(54, 20);
    RST = 1'b1;
    snap("mid_reset", 17'd0);
    @(negedge clk);
    RST = 1'b0;

    wait_at(58, 0);
    queue_empty("ball_q", ball_q.size());
    queue_empty("pad_q", pad_q.size());
    queue_empty("rst_q", rst_q.size());
    queue_empty("snap_q", snap_q.size());
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
